// File: rtl/dmb_glink_pkg.sv
// Shared types, defaults and helpers for the G-Link receive monitor.
// Latency: n/a (package only).
// Backpressure: n/a; the receive path is free-running with no flow control.
package dmb_glink_pkg;

    typedef enum logic [1:0] {
        LOS    = 2'b00,
        ACQ    = 2'b01,
        LOCKED = 2'b10
    } link_state_t;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_LOCK_CYC  = 64;
    localparam int DEF_WIN_CYC   = 256;
    localparam int DEF_ERR_THR   = 4;
    localparam int DEF_MAX_FRAME = 4096;

    // Bits needed to encode the values 0..value-1 (never less than 1).
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sat_cntr.sv
// Saturating event counter with synchronous clear taking priority over increment.
// Latency: Q reflects INC one clock after it is sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_cntr #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CLR,
    input  logic         INC,
    output logic [W-1:0] Q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise step unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (CLR) begin
            cnt_d = '0;
        end else if (INC && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register, asynchronously cleared.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Q = cnt_q;

endmodule

// File: rtl/glink_rx_monitor.sv
// G-Link receive front end: registers the deserializer pins, tracks frames and link lock, counts events.
// Latency: RXDATA/RXERR/RXDAV 1 rxclk after the pins; counters, flags and link state 2 rxclk after the pins.
// Backpressure: none; the receiver cannot be stalled, so counters saturate and RXDAV is gated by LINK_UP.
module glink_rx_monitor
    import dmb_glink_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int LOCK_CYC  = DEF_LOCK_CYC,
    parameter int WIN_CYC   = DEF_WIN_CYC,
    parameter int ERR_THR   = DEF_ERR_THR,
    parameter int MAX_FRAME = DEF_MAX_FRAME
) (
    input  logic              rxclk,
    input  logic              rst,
    input  logic [DATA_W-1:0] GLRD,
    input  logic              GRXERR,
    input  logic              GRXDAV,
    input  logic              CLR,
    output logic [DATA_W-1:0] RXDATA,
    output logic              RXDAV,
    output logic              RXERR,
    output logic              LINK_UP,
    output logic [1:0]        LINK_STATE,
    output logic [CNT_W-1:0]  ERR_CNT,
    output logic [CNT_W-1:0]  DAV_CNT,
    output logic [CNT_W-1:0]  FRAME_CNT,
    output logic [CNT_W-1:0]  FRAME_ERR_CNT,
    output logic [CNT_W-1:0]  LOS_CNT,
    output logic              FRAME_OVF
);

    // Length counter must hold MAX_FRAME+1, hence the +2 when MAX_FRAME+1 is a power of two.
    localparam int LEN_W  = clog2(MAX_FRAME + 2);
    localparam int RUN_W  = clog2(LOCK_CYC + 1);
    localparam int WIN_W  = clog2(WIN_CYC);
    localparam int WERR_W = clog2(ERR_THR + 1);

    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_FRAME);
    localparam logic [LEN_W-1:0]  LEN_STOP  = LEN_W'(MAX_FRAME + 1);
    localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_CYC);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_CYC - 1);
    localparam logic [WERR_W-1:0] WERR_THR  = WERR_W'(ERR_THR);

    // Stage 1 (no reset so these can live in the IOB).
    logic [DATA_W-1:0] rxdata_q, rxdata_d;
    logic              rxerr_q, rxerr_d;
    logic              rxdav_q, rxdav_d;

    // Frame tracking.
    logic              dav_dly_q, dav_dly_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              ferr_q, ferr_d;
    logic              ovf_q, ovf_d;
    logic              frm_start, frm_end, frm_err_end, ovf_hit;

    // Link FSM.
    link_state_t       state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d, run_nxt;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [WERR_W-1:0] werr_q, werr_d, werr_incl;
    logic              win_wrap, los_inc;

    // Pin capture inputs.
    always_comb begin
        rxdata_d = GLRD;
        rxerr_d  = GRXERR;
        rxdav_d  = GRXDAV;
    end

    // Stage-1 capture registers, deliberately without reset.
    always_ff @(posedge rxclk) begin
        rxdata_q <= rxdata_d;
        rxerr_q  <= rxerr_d;
        rxdav_q  <= rxdav_d;
    end

    // Frame delineation on the dav envelope, length limit and per-frame error flag.
    always_comb begin
        frm_start   = rxdav_q & ~dav_dly_q;
        frm_end     = ~rxdav_q & dav_dly_q;
        frm_err_end = frm_end & (ferr_q | rxerr_q);
        dav_dly_d   = rxdav_q;
        len_d       = len_q;
        ferr_d      = ferr_q;
        ovf_hit     = 1'b0;
        if (frm_start) begin
            len_d  = LEN_W'(1);
            ferr_d = rxerr_q;
        end else if (rxdav_q) begin
            ferr_d = ferr_q | rxerr_q;
            if (len_q != LEN_STOP) begin
                len_d   = len_q + LEN_W'(1);
                ovf_hit = (len_q == LEN_MAX);
            end
        end
        ovf_d = CLR ? 1'b0 : (ovf_q | ovf_hit);
    end

    // Link lock FSM next state; errors on the wrap cycle open the new window.
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        win_d     = win_q;
        werr_d    = werr_q;
        los_inc   = 1'b0;
        run_nxt   = run_q + RUN_W'(1);
        win_wrap  = (win_q == WIN_LAST);
        werr_incl = (win_wrap ? '0 : werr_q) + WERR_W'(rxerr_q);
        case (state_q)
            LOS: begin
                if (!rxerr_q) begin
                    state_d = ACQ;
                    run_d   = RUN_W'(1);
                end
            end
            ACQ: begin
                if (rxerr_q) begin
                    state_d = LOS;
                end else begin
                    run_d = run_nxt;
                    if (run_nxt == RUN_LOCK) begin
                        state_d = LOCKED;
                        win_d   = '0;
                        werr_d  = '0;
                    end
                end
            end
            LOCKED: begin
                win_d  = win_wrap ? '0 : (win_q + WIN_W'(1));
                werr_d = werr_incl;
                if (rxerr_q && (werr_incl >= WERR_THR)) begin
                    state_d = LOS;
                    los_inc = 1'b1;
                end
            end
            default: state_d = LOS;
        endcase
    end

    // Frame and FSM state registers; a reset mid-frame discards the frame.
    always_ff @(posedge rxclk or posedge rst) begin
        if (rst) begin
            dav_dly_q <= 1'b0;
            len_q     <= '0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
            state_q   <= LOS;
            run_q     <= '0;
            win_q     <= '0;
            werr_q    <= '0;
        end else begin
            dav_dly_q <= dav_dly_d;
            len_q     <= len_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            run_q     <= run_d;
            win_q     <= win_d;
            werr_q    <= werr_d;
        end
    end

    sat_cntr #(.W(CNT_W)) u_err_cnt (
        .CLK(rxclk), .RST(rst), .CLR(CLR), .INC(rxerr_q), .Q(ERR_CNT)
    );
    sat_cntr #(.W(CNT_W)) u_dav_cnt (
        .CLK(rxclk), .RST(rst), .CLR(CLR), .INC(rxdav_q & ~rxerr_q), .Q(DAV_CNT)
    );
    sat_cntr #(.W(CNT_W)) u_frame_cnt (
        .CLK(rxclk), .RST(rst), .CLR(CLR), .INC(frm_end), .Q(FRAME_CNT)
    );
    sat_cntr #(.W(CNT_W)) u_frame_err_cnt (
        .CLK(rxclk), .RST(rst), .CLR(CLR), .INC(frm_err_end), .Q(FRAME_ERR_CNT)
    );
    sat_cntr #(.W(CNT_W)) u_los_cnt (
        .CLK(rxclk), .RST(rst), .CLR(CLR), .INC(los_inc), .Q(LOS_CNT)
    );

    assign RXDATA     = rxdata_q;
    assign RXERR      = rxerr_q;
    assign LINK_UP    = (state_q == LOCKED);
    assign RXDAV      = rxdav_q & LINK_UP;
    assign LINK_STATE = state_q;
    assign FRAME_OVF  = ovf_q;

endmodule

// File: tb/tb_glink_rx_monitor.sv
// Self-checking bench for glink_rx_monitor: directed table, reset corner case, randomized traffic.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_glink_rx_monitor;

    localparam int DATA_W    = 16;
    localparam int CNT_W     = 4;
    localparam int LOCK_CYC  = 64;
    localparam int WIN_CYC   = 256;
    localparam int ERR_THR   = 4;
    localparam int MAX_FRAME = 8;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic              rxclk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] p_glrd;
    logic              p_err, p_dav, p_clr;
    logic [DATA_W-1:0] RXDATA;
    logic              RXDAV, RXERR, LINK_UP, FRAME_OVF;
    logic [1:0]        LINK_STATE;
    logic [CNT_W-1:0]  ERR_CNT, DAV_CNT, FRAME_CNT, FRAME_ERR_CNT, LOS_CNT;

    glink_rx_monitor #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .LOCK_CYC(LOCK_CYC),
        .WIN_CYC(WIN_CYC), .ERR_THR(ERR_THR), .MAX_FRAME(MAX_FRAME)
    ) dut (
        .rxclk(rxclk), .rst(rst), .GLRD(p_glrd), .GRXERR(p_err), .GRXDAV(p_dav), .CLR(p_clr),
        .RXDATA(RXDATA), .RXDAV(RXDAV), .RXERR(RXERR), .LINK_UP(LINK_UP), .LINK_STATE(LINK_STATE),
        .ERR_CNT(ERR_CNT), .DAV_CNT(DAV_CNT), .FRAME_CNT(FRAME_CNT), .FRAME_ERR_CNT(FRAME_ERR_CNT),
        .LOS_CNT(LOS_CNT), .FRAME_OVF(FRAME_OVF)
    );

    always #5 rxclk = ~rxclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural reference state.
    bit              m_rst;
    bit              m_s1_err, m_s1_dav;
    logic [DATA_W-1:0] m_s1_data;
    int m_err_cnt, m_dav_cnt, m_frm_cnt, m_ferr_cnt, m_los_cnt;
    bit m_ovf, m_prev_dav, m_ferr;
    int m_len;                 // words seen in current frame (unbounded)
    int m_state;               // 0 LOS, 1 ACQ, 2 LOCKED
    int m_run;                 // consecutive clean cycles while acquiring
    int m_age;                 // cycles spent in LOCKED
    int m_wid, m_wn;           // current window id and errors seen in it

    typedef struct {
        int n;
        bit dav; bit err; bit clr;
        int e_state; int e_err; int e_dav; int e_frm; int e_ferr; int e_los; int e_ovf;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(int n, bit dav, bit err, bit clr, int st,
                                int ec, int dc, int fc, int fe, int lc, int ov);
        vec_t v;
        v.n = n; v.dav = dav; v.err = err; v.clr = clr; v.e_state = st;
        v.e_err = ec; v.e_dav = dc; v.e_frm = fc; v.e_ferr = fe; v.e_los = lc; v.e_ovf = ov;
        return v;
    endfunction

    function automatic int sat_inc(int v, bit inc);
        return (inc && v < CNT_MAX) ? v + 1 : v;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tchk(string name, int act, int exp);
        if (exp >= 0) chk(name, act, exp);
    endtask

    task automatic model_reset_state();
        m_err_cnt = 0; m_dav_cnt = 0; m_frm_cnt = 0; m_ferr_cnt = 0; m_los_cnt = 0;
        m_ovf = 0; m_prev_dav = 0; m_ferr = 0; m_len = 0;
        m_state = 0; m_run = 0; m_age = 0; m_wid = 0; m_wn = 0;
    endtask

    // One rxclk edge of the reference, using pins as they stand just before the edge.
    task automatic model_edge();
        bit e, d, fstart, fend, fend_err, ovf_set, los_ev;
        int wid;
        e = m_s1_err;
        d = m_s1_dav;
        if (m_rst) begin
            model_reset_state();
        end else begin
            los_ev = 0;
            ovf_set = 0;
            if (m_state == 0) begin
                if (!e) begin m_state = 1; m_run = 1; end
            end else if (m_state == 1) begin
                if (e) m_state = 0;
                else begin
                    m_run++;
                    if (m_run == LOCK_CYC) begin m_state = 2; m_age = 0; m_wid = 0; m_wn = 0; end
                end
            end else begin
                wid = (m_age + 1) / WIN_CYC;
                if (wid != m_wid) begin m_wid = wid; m_wn = 0; end
                if (e) begin
                    m_wn++;
                    if (m_wn >= ERR_THR) begin m_state = 0; los_ev = 1; end
                end
                m_age++;
            end
            fstart   = d && !m_prev_dav;
            fend     = !d && m_prev_dav;
            fend_err = fend && (m_ferr || e);
            if (fstart) begin
                m_len = 1; m_ferr = e;
            end else if (d) begin
                m_len++;
                m_ferr = m_ferr || e;
                if (m_len == MAX_FRAME + 1) ovf_set = 1;
            end
            if (p_clr) begin
                m_err_cnt = 0; m_dav_cnt = 0; m_frm_cnt = 0; m_ferr_cnt = 0; m_los_cnt = 0; m_ovf = 0;
            end else begin
                m_err_cnt  = sat_inc(m_err_cnt, e);
                m_dav_cnt  = sat_inc(m_dav_cnt, d && !e);
                m_frm_cnt  = sat_inc(m_frm_cnt, fend);
                m_ferr_cnt = sat_inc(m_ferr_cnt, fend_err);
                m_los_cnt  = sat_inc(m_los_cnt, los_ev);
                m_ovf      = m_ovf || ovf_set;
            end
            m_prev_dav = d;
        end
        m_s1_err  = p_err;
        m_s1_dav  = p_dav;
        m_s1_data = p_glrd;
    endtask

    task automatic check_all();
        chk("RXDATA", int'(RXDATA), int'(m_s1_data));
        chk("RXERR", int'(RXERR), int'(m_s1_err));
        chk("RXDAV", int'(RXDAV), int'(m_s1_dav && m_state == 2));
        chk("LINK_UP", int'(LINK_UP), int'(m_state == 2));
        chk("LINK_STATE", int'(LINK_STATE), m_state);
        chk("ERR_CNT", int'(ERR_CNT), m_err_cnt);
        chk("DAV_CNT", int'(DAV_CNT), m_dav_cnt);
        chk("FRAME_CNT", int'(FRAME_CNT), m_frm_cnt);
        chk("FRAME_ERR_CNT", int'(FRAME_ERR_CNT), m_ferr_cnt);
        chk("LOS_CNT", int'(LOS_CNT), m_los_cnt);
        chk("FRAME_OVF", int'(FRAME_OVF), int'(m_ovf));
    endtask

    // Pins are already driven; advance the model and the DUT by one edge, then compare.
    task automatic step();
        model_edge();
        @(posedge rxclk);
        #1;
        check_all();
    endtask

    initial begin
        int dav_left;
        int rate;

        // Directed table: lock timing, frames, saturation, clear, overflow, loss of lock.
        tbl.push_back(mk(1,   0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(62,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,   0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(6,   0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(6,   1, 0, 0, 2, -1, -1, -1, -1, -1, -1));
        tbl.push_back(mk(4,   0, 0, 0, 2, 0, 6, 1, 0, 0, 0));
        tbl.push_back(mk(20,  1, 0, 0, 2, -1, -1, -1, -1, -1, -1));
        tbl.push_back(mk(4,   0, 0, 0, 2, 0, 15, 2, 0, 0, 1));
        tbl.push_back(mk(3,   1, 0, 0, -1, -1, -1, -1, -1, -1, -1));
        tbl.push_back(mk(1,   1, 0, 1, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,   1, 0, 0, 2, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(4,   0, 0, 0, 2, 0, 2, 1, 0, 0, 0));
        tbl.push_back(mk(11,  1, 0, 0, -1, -1, -1, -1, -1, -1, -1));
        tbl.push_back(mk(1,   1, 1, 0, -1, -1, -1, -1, -1, -1, -1));
        tbl.push_back(mk(4,   0, 0, 0, 2, 1, 13, 2, 1, 0, 1));
        tbl.push_back(mk(256, 0, 0, 0, 2, 1, 13, 2, 1, 0, 1));
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(9, 0, 0, 0, 2, -1, -1, -1, -1, -1, -1));
            tbl.push_back(mk(1, 0, 1, 0, 2, -1, -1, -1, -1, -1, -1));
        end
        tbl.push_back(mk(1,   0, 0, 0, 0, 5, 13, 2, 1, 1, 1));
        tbl.push_back(mk(70,  0, 0, 0, 2, 5, 13, 2, 1, 1, 1));
        for (int w = 0; w < 5; w++) begin
            for (int k = 0; k < 3; k++) begin
                tbl.push_back(mk(49, 0, 0, 0, 2, -1, -1, -1, -1, -1, -1));
                tbl.push_back(mk(1,  0, 1, 0, 2, -1, -1, -1, -1, -1, -1));
            end
            tbl.push_back(mk(106, 0, 0, 0, 2, -1, -1, -1, -1, -1, -1));
        end
        tbl.push_back(mk(1,   0, 0, 0, 2, 15, 13, 2, 1, 1, 1));

        // Reset with clean idle pins.
        rst = 1'b1; p_glrd = '0; p_err = 1'b0; p_dav = 1'b0; p_clr = 1'b0;
        m_rst = 1'b1;
        m_s1_err = 1'b0; m_s1_dav = 1'b0; m_s1_data = '0;
        model_reset_state();
        repeat (3) step();
        rst = 1'b0;
        m_rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            p_dav = tbl[i].dav; p_err = tbl[i].err; p_clr = tbl[i].clr;
            for (int c = 0; c < tbl[i].n; c++) begin
                p_glrd = 16'($urandom);
                step();
            end
            tchk("tbl_LINK_STATE", int'(LINK_STATE), tbl[i].e_state);
            tchk("tbl_ERR_CNT", int'(ERR_CNT), tbl[i].e_err);
            tchk("tbl_DAV_CNT", int'(DAV_CNT), tbl[i].e_dav);
            tchk("tbl_FRAME_CNT", int'(FRAME_CNT), tbl[i].e_frm);
            tchk("tbl_FRAME_ERR_CNT", int'(FRAME_ERR_CNT), tbl[i].e_ferr);
            tchk("tbl_LOS_CNT", int'(LOS_CNT), tbl[i].e_los);
            tchk("tbl_FRAME_OVF", int'(FRAME_OVF), tbl[i].e_ovf);
        end
        p_err = 1'b0; p_clr = 1'b0;

        // Reset asserted mid-frame: outputs drop at once, the frame is never counted.
        p_dav = 1'b1;
        repeat (4) step();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_LINK_STATE", int'(LINK_STATE), 0);
        chk("rst_LINK_UP", int'(LINK_UP), 0);
        chk("rst_RXDAV", int'(RXDAV), 0);
        chk("rst_ERR_CNT", int'(ERR_CNT), 0);
        chk("rst_DAV_CNT", int'(DAV_CNT), 0);
        chk("rst_FRAME_CNT", int'(FRAME_CNT), 0);
        chk("rst_FRAME_ERR_CNT", int'(FRAME_ERR_CNT), 0);
        chk("rst_LOS_CNT", int'(LOS_CNT), 0);
        chk("rst_FRAME_OVF", int'(FRAME_OVF), 0);
        m_rst = 1'b1;
        model_reset_state();
        p_dav = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        m_rst = 1'b0;
        repeat (4) step();
        chk("post_rst_FRAME_CNT", int'(FRAME_CNT), 0);
        chk("post_rst_DAV_CNT", int'(DAV_CNT), 0);

        // Randomized traffic in blocks of differing error rate.
        dav_left = 0;
        for (int blk = 0; blk < 15; blk++) begin
            rate = (blk % 3 == 0) ? 0 : ((blk % 3 == 1) ? 120 : 25);
            for (int c = 0; c < 300; c++) begin
                if (dav_left == 0) begin
                    p_dav = ~p_dav;
                    dav_left = p_dav ? int'($urandom_range(12, 1)) : int'($urandom_range(4, 1));
                end
                dav_left--;
                p_err = (rate != 0) && ($urandom_range(rate - 1, 0) == 0);
                p_clr = ($urandom_range(199, 0) == 0);
                p_glrd = 16'($urandom);
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
